mem_ctrl: RTL and testbench

Memory controller that services load/store requests from the load-store buffer and drives the byte-wide RAM/IO port. It accepts one request at a time, serialises it into 1, 2 or 4 byte accesses, assembles and sign/zero-extends load data, and returns a single-cycle completion pulse to the load-store buffer. It sits between the load-store buffer and the top-level `mem_*` RAM pins.

---
 rtl/mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_mem_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// Byte-serial load/store controller between the load-store buffer and the byte-wide RAM/IO port.
// Optional IO back-pressure on stores is enabled with `define MEMCTRL_IO_STALL_EN.
`timescale 1ns/1ps
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        valid_from_lsb,
    input  logic [6:0]  inst_type_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [31:0] data_from_lsb,
    input  logic        rollback_from_rob,
    output logic        valid_to_lsb,
    output logic [31:0] data_to_lsb,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

    state_t      state_reg, state_next;
    logic        store_reg, store_next;
    logic [2:0]  funct3_reg, funct3_next;
    logic [31:0] addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    // Loads: number of addresses issued. Stores: index of the byte on the port.
    logic [2:0]  k_reg, k_next;
    logic [1:0]  cap_reg, cap_next;
    logic        issued_reg, issued_next;
    logic        din_vld_reg, din_vld_next;
    logic [7:0]  lane_reg [4];
    logic [7:0]  lane_next [4];
    logic [31:0] mem_a_reg, mem_a_next;
    logic [7:0]  mem_dout_reg, mem_dout_next;
    logic        mem_wr_reg, mem_wr_next;
    logic        valid_reg, valid_next;
    logic [31:0] rdata_reg, rdata_next;

    logic        capture_en;
    logic [3:0]  lane_hit;
    logic [31:0] word_now;
    logic [2:0]  last_idx;
    logic [2:0]  tgt;
    logic [3:0]  unused_sigs;

    assign unused_sigs = {inst_type_from_lsb[5:3], io_buffer_full};

    function automatic logic io_block(input logic [31:0] a);
`ifdef MEMCTRL_IO_STALL_EN
        return (a[17:16] == 2'b11) && io_buffer_full;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3[1:0])
            2'b00:   return {{24{~f3[2] & w[7]}}, w[7:0]};
            2'b01:   return {{16{~f3[2] & w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign last_idx   = (funct3_reg[1:0] == 2'b00) ? 3'd0 :
                        (funct3_reg[1:0] == 2'b01) ? 3'd1 : 3'd3;
    assign capture_en = (state_reg == LOAD) && !rollback_from_rob && din_vld_reg;
    // A store byte that was not actually written (IO stall or rdy freeze) is retried.
    assign tgt        = mem_wr_reg ? (k_reg + 3'd1) : k_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi]          = capture_en && (cap_reg == 2'(gi));
            assign lane_next[gi]         = lane_hit[gi] ? mem_din : lane_reg[gi];
            assign word_now[8*gi +: 8]   = lane_next[gi];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        store_next    = store_reg;
        funct3_next   = funct3_reg;
        addr_next     = addr_reg;
        data_next     = data_reg;
        k_next        = k_reg;
        cap_next      = cap_reg;
        issued_next   = issued_reg;
        din_vld_next  = din_vld_reg;
        mem_a_next    = mem_a_reg;
        mem_dout_next = mem_dout_reg;
        mem_wr_next   = 1'b0;
        valid_next    = 1'b0;
        rdata_next    = rdata_reg;
        case (state_reg)
            IDLE: begin
                mem_a_next    = '0;
                mem_dout_next = '0;
                issued_next   = 1'b0;
                din_vld_next  = 1'b0;
                rdata_next    = '0;
                if (valid_from_lsb && !rollback_from_rob) begin
                    store_next  = inst_type_from_lsb[6];
                    funct3_next = inst_type_from_lsb[2:0];
                    addr_next   = addr_from_lsb;
                    data_next   = data_from_lsb;
                    cap_next    = '0;
                    mem_a_next  = addr_from_lsb;
                    if (inst_type_from_lsb[6]) begin
                        state_next    = STORE;
                        k_next        = 3'd0;
                        mem_dout_next = data_from_lsb[7:0];
                        mem_wr_next   = !io_block(addr_from_lsb);
                    end else begin
                        state_next  = LOAD;
                        k_next      = 3'd1;
                        issued_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (rollback_from_rob) begin
                    state_next   = IDLE;
                    mem_a_next   = '0;
                    issued_next  = 1'b0;
                    din_vld_next = 1'b0;
                end else begin
                    din_vld_next = issued_reg;
                    if (din_vld_reg)
                        cap_next = cap_reg + 2'd1;
                    if (k_reg <= last_idx) begin
                        mem_a_next  = addr_reg + {29'd0, k_reg};
                        k_next      = k_reg + 3'd1;
                        issued_next = 1'b1;
                    end else begin
                        mem_a_next  = '0;
                        issued_next = 1'b0;
                    end
                    if (din_vld_reg && ({1'b0, cap_reg} == last_idx)) begin
                        state_next   = DONE;
                        valid_next   = 1'b1;
                        rdata_next   = extend(funct3_reg, word_now);
                        mem_a_next   = '0;
                        issued_next  = 1'b0;
                        din_vld_next = 1'b0;
                    end
                end
            end
            STORE: begin
                if (mem_wr_reg && (k_reg == last_idx)) begin
                    state_next    = DONE;
                    valid_next    = 1'b1;
                    rdata_next    = '0;
                    mem_a_next    = '0;
                    mem_dout_next = '0;
                end else begin
                    k_next        = tgt;
                    mem_a_next    = addr_reg + {29'd0, tgt};
                    mem_dout_next = data_reg[{tgt[1:0], 3'b000} +: 8];
                    mem_wr_next   = !io_block(addr_reg + {29'd0, tgt});
                end
            end
            DONE: begin
                // A pulse swallowed by a rdy freeze is re-issued once rdy returns.
                if (valid_reg || (!store_reg && rollback_from_rob)) begin
                    state_next = IDLE;
                    rdata_next = '0;
                end else begin
                    valid_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            store_reg    <= 1'b0;
            funct3_reg   <= '0;
            addr_reg     <= '0;
            data_reg     <= '0;
            k_reg        <= '0;
            cap_reg      <= '0;
            issued_reg   <= 1'b0;
            din_vld_reg  <= 1'b0;
            for (int i = 0; i < 4; i++)
                lane_reg[i] <= '0;
            mem_a_reg    <= '0;
            mem_dout_reg <= '0;
            mem_wr_reg   <= 1'b0;
            valid_reg    <= 1'b0;
            rdata_reg    <= '0;
        end else if (!rdy) begin
            mem_wr_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            store_reg    <= store_next;
            funct3_reg   <= funct3_next;
            addr_reg     <= addr_next;
            data_reg     <= data_next;
            k_reg        <= k_next;
            cap_reg      <= cap_next;
            issued_reg   <= issued_next;
            din_vld_reg  <= din_vld_next;
            lane_reg     <= lane_next;
            mem_a_reg    <= mem_a_next;
            mem_dout_reg <= mem_dout_next;
            mem_wr_reg   <= mem_wr_next;
            valid_reg    <= valid_next;
            rdata_reg    <= rdata_next;
        end
    end

    assign mem_a        = mem_a_reg;
    assign mem_dout     = mem_dout_reg;
    assign mem_wr       = mem_wr_reg;
    assign valid_to_lsb = valid_reg;
    assign data_to_lsb  = rdata_reg;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed cases plus randomized requests checked against a byte-level memory model.
// The RAM model shares the system rdy freeze: it neither reads nor writes while rdy is low.
`timescale 1ns/1ps
module tb_mem_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        valid_from_lsb = 1'b0;
    logic [6:0]  inst_type_from_lsb = '0;
    logic [31:0] addr_from_lsb = '0;
    logic [31:0] data_from_lsb = '0;
    logic        rollback_from_rob = 1'b0;
    logic        valid_to_lsb;
    logic [31:0] data_to_lsb;
    logic [7:0]  mem_din = '0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

`ifdef MEMCTRL_IO_STALL_EN
    localparam bit IO_STALL = 1'b1;
`else
    localparam bit IO_STALL = 1'b0;
`endif

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .valid_from_lsb(valid_from_lsb), .inst_type_from_lsb(inst_type_from_lsb),
        .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
        .rollback_from_rob(rollback_from_rob),
        .valid_to_lsb(valid_to_lsb), .data_to_lsb(data_to_lsb),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;

    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a))
            return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk) begin
        if (rdy) begin
            if (mem_wr)
                ram[mem_a] = mem_dout;
            mem_din <= ram_rd(mem_a);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: rb = rollback cycle (-1 none), rdy low for cycles [s0, s0+slen), io full cycles [0, io_hi).
    task automatic run_req(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                           input int rb, input int s0, input int slen, input int io_hi);
        int n, pulse_cyc, io_stalls, exp_pulse;
        logic [31:0] got_data, exp_data, bits;
        logic [7:0] exp_b [4];
        int wc[$];
        logic [31:0] wa[$];
        logic [7:0] wd[$];
        n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        for (int j = 0; j < 4; j++)
            exp_b[j] = st ? d[8*j +: 8] : ram_rd(a + 32'(j));
        pulse_cyc = -1;
        got_data = '0;
        @(posedge clk); #1;
        valid_from_lsb = 1'b1;
        inst_type_from_lsb = {st, 3'b000, f3};
        addr_from_lsb = a;
        data_from_lsb = d;
        rdy = 1'b1;
        rollback_from_rob = 1'b0;
        io_buffer_full = (io_hi > 0);
        for (int c = 0; c < 40; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                rdy = !(slen > 0 && c >= s0 && c < s0 + slen);
                rollback_from_rob = (c == rb);
                io_buffer_full = (c < io_hi);
                if (!st && rb >= 0 && c > rb)
                    valid_from_lsb = 1'b0;
            end
            @(negedge clk);
            if (mem_wr && rdy) begin
                wc.push_back(c);
                wa.push_back(mem_a);
                wd.push_back(mem_dout);
            end
            if (!st && rb >= 0 && c == rb + 1)
                check("rb_idle_mem_a", mem_a, 32'h0);
            if (valid_to_lsb) begin
                pulse_cyc = c;
                got_data = data_to_lsb;
                break;
            end
            if (rb >= 0 && !st && c >= rb + 10)
                break;
        end
        @(posedge clk); #1;
        valid_from_lsb = 1'b0;
        rollback_from_rob = 1'b0;
        rdy = 1'b1;
        io_buffer_full = 1'b0;
        @(negedge clk);
        check("after_idle", {valid_to_lsb, mem_wr, mem_a}, 34'h0);

        if (!st) begin
            check("load_no_write", wc.size(), 0);
            if (rb >= 0) begin
                check("rb_no_pulse", pulse_cyc, -1);
            end else begin
                bits = {exp_b[3], exp_b[2], exp_b[1], exp_b[0]};
                exp_data = bits;
                if (n < 4) begin
                    exp_data = bits & ((32'd1 << (8*n)) - 1);
                    if (!f3[2] && exp_data[8*n-1])
                        exp_data = exp_data | ~((32'd1 << (8*n)) - 1);
                end
                check("load_pulse_cyc", pulse_cyc, n + 2 + slen);
                check("load_data", got_data, exp_data);
            end
        end else begin
            io_stalls = (IO_STALL && a[17:16] == 2'b11) ? io_hi : 0;
            exp_pulse = n + 1 + io_stalls;
            check("store_pulse_cyc", pulse_cyc, exp_pulse);
            check("store_data0", got_data, 32'h0);
            check("store_nwrites", wc.size(), n);
            for (int j = 0; j < n && j < wc.size(); j++) begin
                check("store_w_cyc", wc[j], 1 + io_stalls + j);
                check("store_w_addr", wa[j], a + 32'(j));
                check("store_w_byte", {24'h0, wd[j]}, {24'h0, exp_b[j]});
                check("store_ram", {24'h0, ram_rd(a + 32'(j))}, {24'h0, exp_b[j]});
            end
        end
        $display("txn %s f3=%0d addr=%h data=%h rb=%0d stall=%0d@%0d pulse=%0d result=%h",
                 st ? "ST" : "LD", f3, a, d, rb, slen, s0, pulse_cyc, got_data);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {valid_to_lsb, data_to_lsb, mem_dout, mem_a, mem_wr}, 74'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {valid_to_lsb, mem_wr, mem_a}, 34'h0);

        ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
        ram[32'h200] = 8'h80;
        ram[32'h300] = 8'h34; ram[32'h301] = 8'hF2;

        run_req(1'b0, 3'b010, 32'h100, 32'h0, -1, 0, 0, 0);
        run_req(1'b0, 3'b000, 32'h200, 32'h0, -1, 0, 0, 0);
        run_req(1'b0, 3'b100, 32'h200, 32'h0, -1, 0, 0, 0);
        run_req(1'b0, 3'b001, 32'h300, 32'h0, -1, 0, 0, 0);
        run_req(1'b1, 3'b010, 32'h400, 32'hDEADBEEF, -1, 0, 0, 0);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, 2, 0, 0, 0);
        run_req(1'b1, 3'b010, 32'h500, 32'hCAFEF00D, 2, 0, 0, 0);
        run_req(1'b1, 3'b000, 32'h30000, 32'h41, -1, 0, 0, 2);
        run_req(1'b0, 3'b010, 32'h100, 32'h0, -1, 2, 2, 0);
        run_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, -1, 0, 0, 0);
        run_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h0000A55A, -1, 0, 0, 0);

        // Asynchronous reset in the middle of a load clears outputs without a clock edge.
        @(posedge clk); #1;
        valid_from_lsb = 1'b1;
        inst_type_from_lsb = 7'b0000010;
        addr_from_lsb = 32'h100;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("async_reset", {valid_to_lsb, data_to_lsb, mem_dout, mem_a, mem_wr}, 74'h0);
        valid_from_lsb = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        for (int t = 0; t < 40; t++) begin
            bit st;
            logic [2:0] f3;
            logic [31:0] a;
            int n, rb, s0, slen;
            st = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, st ? 2 : 4))
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            a = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFD : ($urandom & 32'hFFFCFFFF);
            n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
            rb = -1; s0 = 0; slen = 0;
            if (!st && $urandom_range(0, 5) == 0)
                rb = $urandom_range(1, n + 1);
            else if (!st && $urandom_range(0, 1) == 1) begin
                s0 = $urandom_range(1, n + 1);
                slen = $urandom_range(1, 3);
            end
            run_req(st, f3, a, $urandom, rb, s0, slen, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
